// File: rtl/io_step_controller_pkg.sv
// Shared definitions for the I/O step controller.
//   state_t             : FSM encodings (3-bit)
//   KIND_IN / KIND_OUT  : value of the kind register for in / out instructions
//   DEBOUNCE_CYCLES_DEF : default debounce length (board clock)
package io_step_controller_pkg;
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARM          = 3'd1,
    WAIT_PRESS   = 3'd2,
    WAIT_RELEASE = 3'd3,
    COMMIT       = 3'd4
  } state_t;

  localparam logic KIND_IN  = 1'b0;
  localparam logic KIND_OUT = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/io_step_controller_if.sv
// Core-side handshake between the decoder/datapath and the I/O step controller.
//   in_req, out_req : decoder strobes for the in / out instruction
//   out_data        : value to display for out
//   halt, commit    : stall and one-cycle retire pulse back to the core
//   in_data         : captured switch value for the register write path
// master = core side, slave = controller.
interface io_step_controller_if;
  logic        in_req;
  logic        out_req;
  logic [31:0] out_data;
  logic        halt;
  logic        commit;
  logic [31:0] in_data;

  modport master (output in_req, out_req, out_data, input halt, commit, in_data);
  modport slave  (input in_req, out_req, out_data, output halt, commit, in_data);
endinterface

// File: rtl/io_step_controller_btn_debouncer.sv
// Button conditioner: 2-FF synchronizer followed by a level debouncer.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button
//   db       : debounced level; flips after DEBOUNCE_CYCLES consecutive
//              synchronized samples that differ from it
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // this sample is the DEBOUNCE_CYCLES-th differing one
        db  <= sync2;
        cnt <= '0;
      end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_step_controller.sv
// Stalls the core on in/out instructions until the operator confirms with a
// debounced press-and-release, then retires the instruction with one commit
// cycle. in captures the switches on the press; out latches the display on
// the commit edge.
//   clk, rst : clock, synchronous active-high reset
//   core     : decoder/core handshake (in_req, out_req, out_data, halt,
//              commit, in_data)
//   btn, sw  : raw confirm button and switches
//   display  : latched display value
//   busy     : FSM not idle
module io_step_controller
  import io_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SW_W            = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  io_step_controller_if.slave  core,
  input  logic                 btn,
  input  logic [SW_W-1:0]      sw,
  output logic [31:0]          display,
  output logic                 busy
);
  state_t            state, nxt;
  logic              kind;
  logic              db;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic              req;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .db  (db)
  );

  assign req  = core.in_req | core.out_req;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      kind         <= KIND_IN;
      core.in_data <= '0;
      display      <= '0;
      sw_s1        <= '0;
      sw_s2        <= '0;
    end else begin
      state <= nxt;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      // in wins if the decoder ever raises both strobes
      if (state == IDLE && req)
        kind <= core.out_req & ~core.in_req;
      if (state == WAIT_PRESS && db && kind == KIND_IN)
        core.in_data <= 32'(sw_s2);
      if (state == COMMIT && kind == KIND_OUT)
        display <= core.out_data;
    end
  end

  // halt is combinational so the stall covers the very cycle the request shows up
  always_comb begin
    nxt         = state;
    core.halt   = 1'b0;
    core.commit = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          core.halt = 1'b1;
          nxt       = db ? ARM : WAIT_PRESS;
        end
      end
      ARM: begin
        core.halt = 1'b1;
        if (!db) nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        core.halt = 1'b1;
        if (db) nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        core.halt = 1'b1;
        if (!db) nxt = COMMIT;
      end
      COMMIT: begin
        core.commit = 1'b1;
        nxt         = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_io_step_controller.sv
module tb_io_step_controller;
  import io_step_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [17:0] sw;
  logic [31:0] display;
  logic        busy;

  io_step_controller_if core_if();

  io_step_controller #(.DEBOUNCE_CYCLES(4), .SW_W(18)) dut (
    .clk     (clk),
    .rst     (rst),
    .core    (core_if.slave),
    .btn     (btn),
    .sw      (sw),
    .display (display),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in_d;
    logic [31:0] disp_b;
    logic [31:0] disp_a;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.state == s) break;
    end
    chk(name, 32'(dut.state), 32'(s));
  endtask

  task automatic wait_db(input logic lvl, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.u_db.db == lvl) break;
    end
    chk(name, 32'(dut.u_db.db), 32'(lvl));
  endtask

  // waits for the commit cycle, then drops the strobes as the PC moves on
  task automatic wait_commit(input int budget, input string name);
    int i;
    bit seen = 0;
    for (i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (core_if.commit) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
    step(1);
    core_if.in_req  = 1'b0;
    core_if.out_req = 1'b0;
  endtask

  // monitor: every commit pops one expected transaction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_if.commit) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_commit: got commit=1 expected no commit");
        end else begin
          e = sb.pop_front();
          chk("commit_in_data", core_if.in_data, e.in_d);
          chk("commit_display_before", display, e.disp_b);
          chk("commit_halt", 32'(core_if.halt), 32'd0);
          @(negedge clk);
          chk("display_after_commit", display, e.disp_a);
          chk("commit_one_cycle", 32'(core_if.commit), 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; btn = 1'b1; sw = '0;
    core_if.in_req = 1'b0; core_if.out_req = 1'b0; core_if.out_data = '0;

    // reset with button held
    step(3);
    @(negedge clk);
    chk("rst_halt", 32'(core_if.halt), 32'd0);
    chk("rst_commit", 32'(core_if.commit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_data", core_if.in_data, 32'd0);
    chk("rst_display", display, 32'd0);
    chk("rst_db", 32'(dut.u_db.db), 32'd0);
    step(1); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (core_if.halt) chk("idle_no_halt", 32'(core_if.halt), 32'd0);
    end
    @(negedge clk);
    chk("db_rises_6_cycles", 32'(dut.u_db.db), 32'd1);
    step(1); btn = 1'b0;
    wait_db(1'b0, 20, "db_falls");

    // in path
    step(1);
    sw = 18'h2A5A5; core_if.in_req = 1'b1;
    sb.push_back('{in_d: 32'h0002A5A5, disp_b: 32'h0, disp_a: 32'h0});
    @(negedge clk);
    chk("in_halt_req_cycle", 32'(core_if.halt), 32'd1);
    step(1);
    chk("in_wait_press", 32'(dut.state), 32'(WAIT_PRESS));
    btn = 1'b1; step(10);
    chk("in_data_after_press", core_if.in_data, 32'h0002A5A5);
    chk("in_wait_release", 32'(dut.state), 32'(WAIT_RELEASE));
    sw = 18'h0; btn = 1'b0;
    wait_commit(40, "in_commit_seen");
    @(negedge clk);
    chk("in_idle_after", 32'(busy), 32'd0);

    // out path
    step(1);
    core_if.out_data = 32'hDEADBEEF; core_if.out_req = 1'b1;
    sb.push_back('{in_d: 32'h0002A5A5, disp_b: 32'h0, disp_a: 32'hDEADBEEF});
    @(negedge clk);
    chk("out_halt_req_cycle", 32'(core_if.halt), 32'd1);
    step(1); btn = 1'b1; step(10);
    chk("out_display_held", display, 32'h0);
    btn = 1'b0;
    wait_commit(40, "out_commit_seen");

    // bounce during WAIT_PRESS
    step(2);
    sw = 18'h00123; core_if.in_req = 1'b1;
    sb.push_back('{in_d: 32'h00000123, disp_b: 32'hDEADBEEF, disp_a: 32'hDEADBEEF});
    step(1);
    for (int i = 0; i < 10; i++) begin btn = ~btn; step(2); end
    btn = 1'b0; step(4);
    chk("bounce_state", 32'(dut.state), 32'(WAIT_PRESS));
    chk("bounce_in_data", core_if.in_data, 32'h0002A5A5);
    btn = 1'b1; step(10); btn = 1'b0;
    wait_commit(40, "bounce_commit_seen");

    // held button before out_req
    step(2); btn = 1'b1;
    wait_db(1'b1, 20, "held_db_high");
    step(1);
    core_if.out_data = 32'h12345678; core_if.out_req = 1'b1;
    sb.push_back('{in_d: 32'h00000123, disp_b: 32'hDEADBEEF, disp_a: 32'h12345678});
    step(1);
    chk("held_arm", 32'(dut.state), 32'(ARM));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_if.commit) chk("held_no_commit", 32'(core_if.commit), 32'd0);
    end
    chk("held_still_arm", 32'(dut.state), 32'(ARM));
    step(1); btn = 1'b0;
    wait_state(WAIT_PRESS, 20, "held_to_wait_press");
    step(1); btn = 1'b1; step(10); btn = 1'b0;
    wait_commit(40, "held_commit_seen");

    // reset in WAIT_RELEASE
    step(2);
    sw = 18'h00ABC; core_if.in_req = 1'b1;
    step(1); btn = 1'b1;
    wait_state(WAIT_RELEASE, 20, "rr_wait_release");
    chk("rr_captured", core_if.in_data, 32'h00000ABC);
    step(1); rst = 1'b1; core_if.in_req = 1'b0; btn = 1'b0;
    step(1);
    chk("rr_state_idle", 32'(dut.state), 32'(IDLE));
    chk("rr_in_data", core_if.in_data, 32'd0);
    chk("rr_display", display, 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    step(1); rst = 1'b0;
    step(20);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
